// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared raster geometry for the CHIP-8 console video path.
//   - Default timing constants (256x240 visible, 309 clocks/line, 262 lines).
//   - Derived sync window and counter-wrap positions.
//   - pos_t: 9-bit beam position type used by the timing generator and the
//     video driver that fetches VRAM pixels from hpos/vpos.
// -----------------------------------------------------------------------------
package video_timing_pkg;

  // Horizontal geometry, in pixel clocks.
  localparam int H_DISPLAY = 256;  // visible clocks per line
  localparam int H_BACK    = 23;   // left border
  localparam int H_FRONT   = 7;    // right border
  localparam int H_SYNC    = 23;   // hsync width

  // Vertical geometry, in lines.
  localparam int V_DISPLAY = 240;  // visible lines
  localparam int V_TOP     = 5;    // top border
  localparam int V_BOTTOM  = 14;   // bottom border
  localparam int V_SYNC    = 3;    // vsync width

  // Sync follows the visible area plus the trailing border; the counter
  // wraps after the last sync position plus the leading border.
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;                       // 263
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;                 // 285
  localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1; // 308

  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;                      // 254
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;                 // 256
  localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1; // 261

  // Beam position. Geometries needing more than 512 positions per axis
  // are not supported.
  typedef logic [8:0] pos_t;

endpackage

// File: rtl/ghost_video_timing.sv
// -----------------------------------------------------------------------------
// ghost_video_timing
// Free-running raster timing generator for the CHIP-8 console top level.
//
// Ports
//   clk         in   pixel clock, all state on the rising edge
//   reset       in   asynchronous, active-high reset
//   hsync       out  horizontal sync, registered
//   vsync       out  vertical sync, registered (CPU 60 Hz frame reference)
//   display_on  out  beam inside visible area (combinational from counters)
//   hpos        out  horizontal position, 0..H_MAX
//   vpos        out  vertical position, 0..V_MAX
//   frame_tick  out  high while hpos==0 and vpos==0 (combinational)
//
// Configuration
//   GHOST_VIDEO_SYNC_NEG_EN  when defined, hsync/vsync are active-low and
//                            reset to 1; otherwise active-high, reset to 0.
// -----------------------------------------------------------------------------
module ghost_video_timing #(
  parameter int H_DISPLAY = video_timing_pkg::H_DISPLAY,
  parameter int H_BACK    = video_timing_pkg::H_BACK,
  parameter int H_FRONT   = video_timing_pkg::H_FRONT,
  parameter int H_SYNC    = video_timing_pkg::H_SYNC,
  parameter int V_DISPLAY = video_timing_pkg::V_DISPLAY,
  parameter int V_TOP     = video_timing_pkg::V_TOP,
  parameter int V_BOTTOM  = video_timing_pkg::V_BOTTOM,
  parameter int V_SYNC    = video_timing_pkg::V_SYNC
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos,
  output logic       frame_tick
);

  import video_timing_pkg::pos_t;

  // Geometry for this instance, cast once to the counter width so every
  // compare below is width-matched.
  localparam pos_t H_VIS        = pos_t'(H_DISPLAY);
  localparam pos_t H_SYNC_START = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t H_SYNC_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t H_MAX        = pos_t'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);

  localparam pos_t V_VIS        = pos_t'(V_DISPLAY);
  localparam pos_t V_SYNC_START = pos_t'(V_DISPLAY + V_BOTTOM);
  localparam pos_t V_SYNC_END   = pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam pos_t V_MAX        = pos_t'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);

  // Inactive sync level. XOR-ing the window compare with it yields the
  // active level for either polarity and doubles as the reset value.
`ifdef GHOST_VIDEO_SYNC_NEG_EN
  localparam logic SYNC_IDLE = 1'b1;
`else
  localparam logic SYNC_IDLE = 1'b0;
`endif

  pos_t hpos_q, hpos_d;
  pos_t vpos_q, vpos_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hpos_d = hpos_q + 9'd1;
    vpos_d = vpos_q;
    if (hpos_q == H_MAX) begin
      hpos_d = '0;
      vpos_d = (vpos_q == V_MAX) ? '0 : vpos_q + 9'd1;
    end

    // Syncs are decoded from the current (pre-edge) position and registered,
    // so each output lags its counter window by one clock but is glitch-free.
    hsync_d = ((hpos_q >= H_SYNC_START) && (hpos_q <= H_SYNC_END)) ^ SYNC_IDLE;
    vsync_d = ((vpos_q >= V_SYNC_START) && (vpos_q <= V_SYNC_END)) ^ SYNC_IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  // Combinational from the counters, so both read 1 while reset is held.
  assign display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
  assign frame_tick = (hpos_q == '0) && (vpos_q == '0);

endmodule

// File: tb/tb_ghost_video_timing.sv
// -----------------------------------------------------------------------------
// tb_ghost_video_timing
// Self-checking bench for ghost_video_timing (default geometry). The expected
// beam state is computed from the number of clocks since reset release using
// division/modulo on the line and frame lengths. Define GHOST_VIDEO_SYNC_NEG_EN
// for both bench and RTL to check the active-low sync build.
// -----------------------------------------------------------------------------
module tb_ghost_video_timing;

  localparam int HT = 309;  // clocks per line
  localparam int VT = 262;  // lines per frame

`ifdef GHOST_VIDEO_SYNC_NEG_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hsync, vsync, display_on, frame_tick;
  logic [8:0] hpos, vpos;

  ghost_video_timing dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  longint t    = 0;   // clocks since reset release (0 while held)
  longint gcyc = 0;   // all clocks since start of simulation

  // Observed-pulse bookkeeping.
  longint last_ft   = -1;
  int     hs_run    = 0;
  int     vs_run    = 0;
  bit     hs_prev   = 1'b0;
  bit     vs_prev   = 1'b0;
  bit     ft_prev   = 1'b0;
  int     vs_pulses = 0;
  int     ft_seen   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: t=%0d got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  function automatic bit hs_window(longint h);
    return (h >= 263) && (h <= 285);
  endfunction

  function automatic bit vs_window(longint v);
    return (v >= 254) && (v <= 256);
  endfunction

  // Compare every output against the reference, then check pulse shapes.
  task automatic check_all();
    longint eh, ev;
    bit ehs, evs, hs_act, vs_act;
    eh  = t % HT;
    ev  = (t / HT) % VT;
    ehs = (t == 0) ? 1'b0 : hs_window((t - 1) % HT);
    evs = (t == 0) ? 1'b0 : vs_window(((t - 1) / HT) % VT);
    check("hpos", hpos, eh);
    check("vpos", vpos, ev);
    check("hsync", hsync, ehs ^ NEG);
    check("vsync", vsync, evs ^ NEG);
    check("display_on", display_on, (eh < 256) && (ev < 240));
    check("frame_tick", frame_tick, (eh == 0) && (ev == 0));

    hs_act = hsync ^ NEG;
    vs_act = vsync ^ NEG;
    if (hs_act && !hs_prev) check("hsync_rise_hpos", hpos, 264);
    if (!hs_act && hs_prev) check("hsync_width", hs_run, 23);
    if (vs_act && !vs_prev) begin
      check("vsync_rise_hpos", hpos, 1);
      check("vsync_rise_vpos", vpos, 254);
    end
    if (!vs_act && vs_prev) begin
      check("vsync_width", vs_run, 3 * 309);
      vs_pulses++;
    end
    hs_run  = hs_act ? hs_run + 1 : 0;
    vs_run  = vs_act ? vs_run + 1 : 0;
    hs_prev = hs_act;
    vs_prev = vs_act;

    if (frame_tick && !ft_prev && !reset && last_ft >= 0) begin
      check("frame_period", gcyc - last_ft, 309 * 262);
      ft_seen++;
    end
    if (frame_tick) last_ft = gcyc;
    ft_prev = frame_tick;
  endtask

  task automatic tick();
    @(posedge clk);
    gcyc++;
    if (!reset) t++;
    #1;
    check_all();
  endtask

  // Assert reset asynchronously between edges and check it took effect
  // before any clock arrives; hold for a few clocks, then release.
  task automatic pulse_reset(input int hold);
    #1;
    reset = 1'b1;
    t = 0;
    #1;
    check_all();
    check("rst_async_hpos", hpos, 0);
    check("rst_async_vpos", vpos, 0);
    check("rst_async_hsync", hsync, NEG);
    check("rst_async_vsync", vsync, NEG);
    check("rst_async_disp", display_on, 1);
    check("rst_async_ft", frame_tick, 1);
    for (int i = 0; i < hold; i++) tick();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset.
    for (int i = 0; i < 3; i++) tick();
    check("por_hsync", hsync, NEG);
    check("por_vsync", vsync, NEG);
    #1;
    reset = 1'b0;

    // Random early reset, placed before the first hsync window.
    for (int i = 0; i < int'($urandom_range(250, 20)); i++) tick();
    pulse_reset(int'($urandom_range(4, 1)));

    // Run to (100,50): covers line wrap and hsync on line 0.
    while (t < 50 * HT + 100) tick();
    check("pre_rst_hpos", hpos, 100);
    check("pre_rst_vpos", vpos, 50);

    // Mid-frame reset; then a full frame from the release.
    pulse_reset(int'($urandom_range(5, 1)));
    tick(); check("post_rst_hpos1", hpos, 1);
    tick(); check("post_rst_hpos2", hpos, 2);
    tick(); check("post_rst_hpos3", hpos, 3);
    while (t < VT * HT + 2) tick();

    check("vsync_pulses", vs_pulses, 1);
    check("frame_ticks", ft_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
